// File: rtl/mv_pkg.sv
// ---------------------------------------------------------------------------
// mv_pkg : constants and types shared by the matrix-vector loader, engine and
//          result writer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mv_pkg;

  localparam int NUM_ROWS = 8;
  localparam int RES_W    = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/avalon_result_writer.sv
// ---------------------------------------------------------------------------
// avalon_result_writer : snapshots the engine results on the rising edge of
//                        done_in and stores them as single-beat Avalon writes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avalon_result_writer
  import mv_pkg::*;
#(
  parameter int                NUM_ROWS    = mv_pkg::NUM_ROWS,
  parameter int                RES_W       = mv_pkg::RES_W,
  parameter int                DATA_W      = 64,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_0040,
  parameter int                ADDR_STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done_in,
  input  logic [NUM_ROWS*RES_W-1:0] c_flat_in,
  output logic [ADDR_W-1:0]         avm_address,
  output logic                      avm_write,
  output logic [DATA_W-1:0]         avm_writedata,
  output logic [DATA_W/8-1:0]       avm_byteenable,
  input  logic                      avm_waitrequest,
  output logic                      wr_done,
  output logic                      complete,
  output logic                      missed,
  output logic                      busy,
  output logic [1:0]                dbg_state,
  output logic [3:0]                dbg_idx
);

  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  wr_state_t          r_state;
  wr_state_t          w_state_nxt;
  logic               r_done_q;
  logic [IDX_W-1:0]   r_idx;
  logic [RES_W-1:0]   r_snap [NUM_ROWS];
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_write;
  logic               r_wr_done;
  logic               r_complete;
  logic               r_missed;
  logic               r_busy;

  logic               w_trigger;
  logic               w_accept;
  logic               w_last;
  logic               w_start;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [RES_W-1:0]   w_elem_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  w_wdata_nxt;
  logic               w_write_nxt;
  logic               w_complete_nxt;
  logic               w_missed_nxt;

  assign w_trigger = done_in & ~r_done_q;
  assign w_accept  = r_write & ~avm_waitrequest;
  assign w_last    = (r_idx == IDX_W'(NUM_ROWS - 1));
  assign w_start   = (r_state == IDLE) & w_trigger;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_state_nxt = WRITE;
      WRITE:   if (w_accept && w_last) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; the first beat's element comes
  // straight from c_flat_in because the snapshot loads on the same edge.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_start) begin
      w_idx_nxt = '0;
    end else if (r_state == WRITE && w_accept) begin
      w_idx_nxt = w_last ? '0 : r_idx + 1'b1;
    end
    w_elem_nxt     = w_start ? c_flat_in[RES_W-1:0] : r_snap[w_idx_nxt];
    w_write_nxt    = (w_state_nxt == WRITE);
    w_addr_nxt     = w_write_nxt ? BASE_ADDR + ADDR_W'(w_idx_nxt) * ADDR_W'(ADDR_STRIDE) : '0;
    w_wdata_nxt    = w_write_nxt ? {{(DATA_W-RES_W){1'b0}}, w_elem_nxt} : '0;
    w_complete_nxt = r_complete;
    if (w_start) begin
      w_complete_nxt = 1'b0;
    end else if (w_state_nxt == FINISH) begin
      w_complete_nxt = 1'b1;
    end
    w_missed_nxt = r_missed | (w_trigger & (r_state != IDLE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q   <= 1'b0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_wr_done  <= 1'b0;
      r_complete <= 1'b0;
      r_missed   <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) r_snap[i] <= '0;
    end else begin
      r_done_q   <= done_in;
      r_idx      <= w_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_write    <= w_write_nxt;
      r_wr_done  <= (w_state_nxt == FINISH);
      r_complete <= w_complete_nxt;
      r_missed   <= w_missed_nxt;
      r_busy     <= w_write_nxt;
      if (w_start) begin
        for (int i = 0; i < NUM_ROWS; i++) r_snap[i] <= c_flat_in[i*RES_W +: RES_W];
      end
    end
  end

  assign avm_address    = r_addr;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = {(DATA_W/8){r_write}};
  assign wr_done        = r_wr_done;
  assign complete       = r_complete;
  assign missed         = r_missed;
  assign busy           = r_busy;
  assign dbg_state      = r_state;
  assign dbg_idx        = 4'(r_idx);

endmodule

`default_nettype wire

// File: tb/tb_avalon_result_writer.sv
// ---------------------------------------------------------------------------
// tb_avalon_result_writer : randomized directed bench for avalon_result_writer
//                           against a queue-of-writes reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_avalon_result_writer;

  localparam int N  = 8;
  localparam int RW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_in;
  logic [N*RW-1:0] c_flat_in;
  logic [31:0]   avm_address;
  logic          avm_write;
  logic [63:0]   avm_writedata;
  logic [7:0]    avm_byteenable;
  logic          avm_waitrequest;
  logic          wr_done;
  logic          complete;
  logic          missed;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_idx;

  int vectors    = 0;
  int miscompares = 0;
  bit exp_missed = 1'b0;
  logic [RW-1:0] exp_q [$];

  avalon_result_writer dut (
    .clk             (clk),
    .rst             (rst),
    .done_in         (done_in),
    .c_flat_in       (c_flat_in),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .wr_done         (wr_done),
    .complete        (complete),
    .missed          (missed),
    .busy            (busy),
    .dbg_state       (dbg_state),
    .dbg_idx         (dbg_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) c_flat_in[i*RW +: RW] = RW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 64'(avm_address), 64'h0);
    check({tag, "_write"}, 64'(avm_write), 64'h0);
    check({tag, "_wdata"}, avm_writedata, 64'h0);
    check({tag, "_be"}, 64'(avm_byteenable), 64'h0);
    check({tag, "_flags"}, 64'({wr_done, complete, missed, busy}), 64'h0);
    check({tag, "_dbg"}, 64'({dbg_state, dbg_idx}), 64'h0);
  endtask

  // Called at a negedge with done_in low for at least one cycle.
  task automatic run_job(input int stall_beat, input int stall_len, input bit rand_stall,
                         input bit change_c, input int glitch_beat, input int rst_beat);
    int beat;
    int cyc;
    int stall_left;
    int total_stalls;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(c_flat_in[i*RW +: RW]);
    done_in = 1'b1;
    avm_waitrequest = 1'b0;
    beat = 0;
    cyc = 1;
    stall_left = (stall_beat == 0) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
    total_stalls = stall_left;
    @(negedge clk);
    check("start_complete_cleared", 64'(complete), 64'h0);
    while (beat < N && cyc < 200) begin
      check($sformatf("b%0d_write", beat), 64'(avm_write), 64'h1);
      check($sformatf("b%0d_addr", beat), 64'(avm_address), 64'(32'h40 + beat));
      check($sformatf("b%0d_data", beat), avm_writedata, {40'h0, exp_q[beat]});
      check($sformatf("b%0d_be", beat), 64'(avm_byteenable), 64'hFF);
      check($sformatf("b%0d_busy", beat), 64'(busy), 64'h1);
      if (beat == rst_beat) begin
        avm_waitrequest = 1'b1;
        #2;
        rst = 1'b1;
        done_in = 1'b0;
        #1;
        check_all_zero("rst_mid_job");
        exp_missed = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          check("post_rst_no_write", 64'(avm_write), 64'h0);
        end
        check("post_rst_state", 64'(dbg_state), 64'h0);
        return;
      end
      if (change_c && beat == 3) fill_random();
      if (glitch_beat >= 0) begin
        if (beat == glitch_beat - 2) done_in = 1'b0;
        if (beat == glitch_beat && !done_in) begin
          done_in = 1'b1;
          exp_missed = 1'b1;
        end
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        beat++;
        stall_left = (beat == stall_beat) ? stall_len :
                     (rand_stall ? int'($urandom_range(0, 2)) : 0);
        if (beat < N) total_stalls += stall_left;
      end
      @(negedge clk);
      cyc++;
    end
    check("job_timeout", 64'(beat), 64'(N));
    avm_waitrequest = 1'b0;
    check("done_pulse", 64'(wr_done), 64'h1);
    check("done_write_low", 64'(avm_write), 64'h0);
    check("done_complete", 64'(complete), 64'h1);
    check("done_busy", 64'(busy), 64'h0);
    check("done_missed", 64'(missed), 64'(exp_missed));
    check("job_latency", 64'(cyc), 64'(9 + total_stalls));
    @(negedge clk);
    check("after_pulse", 64'(wr_done), 64'h0);
    check("back_idle", 64'(dbg_state), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    done_in = 1'b0;
    avm_waitrequest = 1'b0;
    c_flat_in = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_release");

    // Job A: ramp data, no stalls
    for (int i = 0; i < N; i++) c_flat_in[i*RW +: RW] = RW'(24'h000100 + i);
    run_job(-1, 0, 1'b0, 1'b0, -1, -1);
    done_in = 1'b0;
    @(negedge clk);

    // Job B: random data, top element all ones, 3-cycle stall on beat 2
    fill_random();
    c_flat_in[7*RW +: RW] = 24'hFFFFFF;
    run_job(2, 3, 1'b0, 1'b0, -1, -1);
    done_in = 1'b0;
    @(negedge clk);

    // Job C: done_in held high, inputs change mid-job, random stalls
    fill_random();
    run_job(-1, 0, 1'b1, 1'b1, -1, -1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("held_no_rejob", 64'(avm_write), 64'h0);
    end
    check("held_missed", 64'(missed), 64'h0);
    done_in = 1'b0;
    @(negedge clk);

    // Job D: second edge at beat 4 is ignored but flagged
    fill_random();
    run_job(-1, 0, 1'b1, 1'b0, 4, -1);
    done_in = 1'b0;
    @(negedge clk);
    check("missed_sticky", 64'(missed), 64'h1);

    // Job E: a fresh edge is accepted; missed stays set
    fill_random();
    run_job(-1, 0, 1'b1, 1'b0, -1, -1);
    done_in = 1'b0;
    @(negedge clk);

    // Job F: reset during a stalled beat 5
    fill_random();
    run_job(-1, 0, 1'b0, 1'b0, -1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
